// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage with an optional return-address stack.
// Define PC_RAS_EN to build the RAS, ret_en handling and the overflow/underflow flags.
module pc_fetch_unit #(
    parameter int ADDR_W    = 8,
    parameter int INS_W     = 20,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [INS_W-1:0]  ins_in,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] current_address,
    output logic              ins_valid,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam logic [ADDR_W-1:0] PC_RESET = '1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic              valid_q;
    logic [INS_W-1:0]  ins_hold;
    logic [ADDR_W-1:0] ras_top;
    logic              do_ret;
    logic              take_jump;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign take_jump = call_en | jmp_en;

    always_comb begin
        rom_addr = pc_inc;
        if (!reset) begin
            rom_addr = '0;
        end else if (do_ret) begin
            rom_addr = ras_top;
        end else if (take_jump) begin
            rom_addr = jmp_loc;
        end else if (stall) begin
            rom_addr = pc_q;
        end
    end

    // pc_q keeps its reset value across the first valid cycle, so the word read
    // at address 0 during reset is presented tagged with 2^ADDR_W-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= PC_RESET;
            valid_q  <= 1'b0;
            ins_hold <= '0;
        end else begin
            valid_q  <= 1'b1;
            ins_hold <= ins;
            if (valid_q) begin
                pc_q <= rom_addr;
            end
        end
    end

    always_comb begin
        ins = ins_in;
        if (!valid_q || flush) begin
            ins = '0;
        end else if (stall) begin
            ins = ins_hold;
        end
    end

    assign ins_valid       = valid_q & ~flush;
    assign current_address = pc_q;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_q;
    logic [PTR_W-1:0]  sp_dec;
    logic [CNT_W-1:0]  cnt_q;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic              pop;
    logic              ovf_q;
    logic              unf_q;

    // ret outranks call; a call under a ret has no push side effect.
    assign do_ret    = ret_en;
    assign push      = valid_q & call_en & ~ret_en;
    assign pop       = valid_q & ret_en;
    assign sp_dec    = sp_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);
    assign ras_top   = ras_empty ? '0 : ras_mem[sp_dec];

    // Circular buffer: when full, sp_q already points at the oldest entry.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            ras_mem[sp_q] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (push) begin
            sp_q <= sp_q + PTR_W'(1);
            if (ras_full) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (ras_empty) begin
                unf_q <= 1'b1;
            end else begin
                sp_q  <= sp_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;
`else
    logic [RAS_DEPTH-1:0] unused_ras;

    assign do_ret     = 1'b0;
    assign ras_top    = '0;
    assign ras_ovf    = 1'b0;
    assign ras_unf    = 1'b0;
    assign unused_ras = {RAS_DEPTH{ret_en}};
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset sequence, free run with wrap, stall,
// jump, flush, call/return nesting, RAS overflow/underflow and mid-run reset.
module tb_pc_fetch_unit;

    localparam int ADDR_W    = 8;
    localparam int INS_W     = 20;
    localparam int RAS_DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_loc;
    logic              call_en;
    logic              ret_en;
    logic [INS_W-1:0]  ins_in;
    logic [ADDR_W-1:0] rom_addr;
    logic [INS_W-1:0]  ins;
    logic [ADDR_W-1:0] current_address;
    logic              ins_valid;
    logic              ras_ovf;
    logic              ras_unf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .ADDR_W    (ADDR_W),
        .INS_W     (INS_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .jmp_en          (jmp_en),
        .jmp_loc         (jmp_loc),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .ins_in          (ins_in),
        .rom_addr        (rom_addr),
        .ins             (ins),
        .current_address (current_address),
        .ins_valid       (ins_valid),
        .ras_ovf         (ras_ovf),
        .ras_unf         (ras_unf)
    );

    // ROM contents: an address-dependent pattern that is never all zeros.
    function automatic logic [INS_W-1:0] word(input logic [ADDR_W-1:0] a);
        return {4'hC, ~a, a};
    endfunction

    always @(posedge clk) begin
        ins_in <= word(rom_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [ADDR_W-1:0] e_cur,
                              input logic [ADDR_W-1:0] e_rom, input logic [INS_W-1:0] e_ins,
                              input logic e_valid);
        check({tag, "_cur"},   32'(current_address), 32'(e_cur));
        check({tag, "_rom"},   32'(rom_addr),        32'(e_rom));
        check({tag, "_ins"},   32'(ins),             32'(e_ins));
        check({tag, "_valid"}, 32'(ins_valid),       32'(e_valid));
    endtask

    // Apply one cycle's inputs just after the falling edge, then let outputs settle.
    task automatic drive(input logic st, input logic fl, input logic jm, input logic ca,
                         input logic re, input logic [ADDR_W-1:0] loc);
        @(negedge clk);
        stall   = st;
        flush   = fl;
        jmp_en  = jm;
        call_en = ca;
        ret_en  = re;
        jmp_loc = loc;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] cur_e;
        logic [ADDR_W-1:0] nxt;
        logic [ADDR_W-1:0] loc;

        reset = 1'b0; stall = 1'b0; flush = 1'b0; jmp_en = 1'b0;
        call_en = 1'b0; ret_en = 1'b0; jmp_loc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        expect_out("reset", 8'hFF, 8'h00, 20'h0, 1'b0);
        check("reset_ovf", 32'(ras_ovf), 32'(0));
        check("reset_unf", 32'(ras_unf), 32'(0));

        reset = 1'b1; #1;
        expect_out("release", 8'hFF, 8'h00, 20'h0, 1'b0);
        idle();
        expect_out("first_word", 8'hFF, 8'h00, word(8'h00), 1'b1);

        for (int k = 0; k < 256; k++) begin
            a = 8'(k);
            idle();
            expect_out("run", a, a + 8'h01, word(a), 1'b1);
        end
        for (int j = 0; j < 5; j++) begin
            a = 8'(j);
            idle();
            expect_out("wrap", a, a + 8'h01, word(a), 1'b1);
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("stall1", 8'h05, 8'h05, word(8'h04), 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("stall2", 8'h05, 8'h05, word(8'h04), 1'b1);
        idle();
        expect_out("stall_rel", 8'h05, 8'h06, word(8'h05), 1'b1);
        idle();
        expect_out("post_stall", 8'h06, 8'h07, word(8'h06), 1'b1);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h40);
        expect_out("jmp_stall", 8'h07, 8'h40, word(8'h06), 1'b1);
        idle();
        expect_out("jmp_tgt", 8'h40, 8'h41, word(8'h40), 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("flush", 8'h41, 8'h42, 20'h0, 1'b0);
        idle();
        expect_out("post_flush", 8'h42, 8'h43, word(8'h42), 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("flush_stall", 8'h43, 8'h43, 20'h0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("hold_zero", 8'h43, 8'h43, 20'h0, 1'b1);
        idle();
        expect_out("stall_rel2", 8'h43, 8'h44, word(8'h43), 1'b1);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        expect_out("jmp_10", 8'h44, 8'h10, word(8'h44), 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        expect_out("call_80", 8'h10, 8'h80, word(8'h10), 1'b1);
        idle();
        expect_out("at_80", 8'h80, 8'h81, word(8'h80), 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0);
        expect_out("call_c0", 8'h81, 8'hC0, word(8'h81), 1'b1);

        cur_e = 8'hC0;
        nxt = RAS_ON ? 8'h82 : cur_e + 8'h01;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_out("ret1", cur_e, nxt, word(cur_e), 1'b1);
        cur_e = nxt;
        nxt = RAS_ON ? 8'h11 : cur_e + 8'h01;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_out("ret2", cur_e, nxt, word(cur_e), 1'b1);
        cur_e = nxt;
        nxt = RAS_ON ? 8'h00 : cur_e + 8'h01;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_out("ret_empty", cur_e, nxt, word(cur_e), 1'b1);
        cur_e = nxt;
        idle();
        expect_out("after_unf", cur_e, cur_e + 8'h01, word(cur_e), 1'b1);
        check("unf_set", 32'(ras_unf), 32'(RAS_ON));
        check("ovf_clear", 32'(ras_ovf), 32'(0));
        cur_e = cur_e + 8'h01;

        for (int i = 0; i < 5; i++) begin
            loc = 8'h20 + 8'(i * 16);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, loc);
            expect_out("call5", cur_e, loc, word(cur_e), 1'b1);
            cur_e = loc;
        end
        for (int i = 0; i < 4; i++) begin
            nxt = RAS_ON ? (8'h51 - 8'(i * 16)) : cur_e + 8'h01;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
            expect_out("pop4", cur_e, nxt, word(cur_e), 1'b1);
            if (i == 0) check("ovf_set", 32'(ras_ovf), 32'(RAS_ON));
            cur_e = nxt;
        end

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h90);
        expect_out("call_90", cur_e, 8'h90, word(cur_e), 1'b1);
        idle();
        reset = 1'b0; #1;
        check("mid_reset_rom", 32'(rom_addr), 32'(0));
        idle();
        expect_out("mid_reset", 8'hFF, 8'h00, 20'h0, 1'b0);
        check("mid_reset_ovf", 32'(ras_ovf), 32'(0));
        check("mid_reset_unf", 32'(ras_unf), 32'(0));
        reset = 1'b1; #1;
        idle();
        expect_out("re_first", 8'hFF, 8'h00, word(8'h00), 1'b1);
        nxt = RAS_ON ? 8'h00 : 8'h01;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        expect_out("ret_after_reset", 8'h00, nxt, word(8'h00), 1'b1);
        idle();
        check("ret_after_reset_cur", 32'(current_address), 32'(nxt));
        check("ret_after_reset_unf", 32'(ras_unf), 32'(RAS_ON));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
